dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the CPU data-memory interface. Accepts one load/store request at a time from the `cpu` core and returns a single-cycle response after a fixed, parameterised latency. Byte-enabled writes and error flagging are built in. It sits beside `cpu` in the top level and models a multi-cycle data memory, so the pipeline's stall handling can be exercised from `tb_cpu`.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rest`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: CPU presents a request.
- `req_ready`  out  1: responder can accept a request this cycle.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address.
- `req_be`  in  4: byte enables for stores; bit i selects `req_wdata[8i+7:8i]`.
- `req_wdata`  in  32: store data.
- `resp_valid`  out  1: one-cycle response strobe.
- `resp_rdata`  out  32: load data; 0 for stores and errors.
- `resp_err`  out  1: request was misaligned or out of range.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
  - IDLE: `req_ready`=1. When `req_valid`=1, latch `we`, `addr`, `be` and `wdata`, and compute `err`. Go to BUSY, or directly to RESP if `LATENCY`=1.
  - BUSY: a down-counter loaded with `LATENCY-1` decrements each cycle. When the counter reaches 1, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- **Error condition:** `err` = (`addr[1:0]`≠0) OR (`addr` < `BASE_ADDR`) OR (`addr` ≥ `BASE_ADDR`+4·`DEPTH_WORDS`).
- **Word index:** (`addr`−`BASE_ADDR`)[log2(`DEPTH_WORDS`)+1:2].
- **Store:** the array is written in the RESP cycle, only the bytes with `be`=1, and only if `err`=0. A store with `be`=4'b0000 changes nothing and still returns a normal response.
- **Load:** `resp_rdata` is the full 32-bit word; `be` is ignored on loads. On an error, `resp_rdata`=0 and `resp_err`=1.
- **Ordering:** only one request is outstanding at a time. A load issued after a store's response always observes the stored data.
- **No response back-pressure:** the CPU must sample the response in the RESP cycle.
- **Request fields:** ignored whenever `req_ready`=0.

## Timing
- **Reset values:**
  - `req_ready`=1
  - `resp_valid`=0
  - `resp_rdata`=0
  - `resp_err`=0
  - state IDLE, counter 0
- **Array contents:** not reset. Simulation initialises them to 0.
- **Latency:** request accepted on edge T gives `resp_valid` high in the cycle following edge T+`LATENCY`−1. That is, the response is visible `LATENCY` cycles after the acceptance cycle.
- **`req_ready`:** low from the cycle after acceptance through the RESP cycle inclusive.
- **Back-to-back throughput:** a new request can be accepted in the cycle after RESP, giving a maximum of one transaction per `LATENCY`+1 cycles.
- **Response outputs:** `resp_rdata` and `resp_err` are registered, valid only while `resp_valid`=1, and held at 0 otherwise.
- **`rest` in BUSY or RESP:**
  - The transaction is abandoned: no array write, and no `resp_valid` is produced.
  - Next cycle: IDLE with `req_ready`=1.
- **`rest` and `req_valid` in the same cycle:** `rest` wins and the request is not accepted.

## Structure
- **Shared package `dmem_pkg`:**
  - state enum (IDLE/BUSY/RESP)
  - `LAT_W`=4 counter width
  - byte-lane width constant
  - error-check function (alignment and range)
- **Sub-module `dmem_array`:** `DEPTH_WORDS`×32 RAM with synchronous byte-enabled write and asynchronous read. It is the only storage in the block, and FPGA inference may replace it.
- **FSM, counter, request latch and response registers:** live in `dmem_responder`.

## Test plan
- **Reset:** hold `rest`=1 for 2 cycles → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- **Store then load:**
  - Store `addr` 0x10, `be`=4'hF, `wdata`=32'hDEADBEEF with `LATENCY`=2 → `resp_valid` 2 cycles after acceptance, `resp_err`=0.
  - Then load 0x10 → `resp_rdata`=32'hDEADBEEF.
- **Partial store:** store 0x10 with `be`=4'b0010, `wdata`=32'h0000_5500, then load 0x10 → 32'hDEAD55EF.
- **Errors:**
  - Load 0x13 → `resp_err`=1, `resp_rdata`=0.
  - Store to `BASE_ADDR`+4·`DEPTH_WORDS` → `resp_err`=1 and the array is unchanged (verified by a full read-back).
- **Reset mid-transaction:** accept a store to 0x20 with 32'h1234_5678, assert `rest` during BUSY → no `resp_valid`; a later load of 0x20 returns the prior value 0.
- **Back-to-back and latency sweep:** hold `req_valid` high for 4 loads with `LATENCY`=1 and `LATENCY`=15 → accept spacing is `LATENCY`+1 cycles and exactly 4 `resp_valid` pulses occur.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LAT_W  = 4;
    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    // span is the window size in bytes; 33 bits so base+span cannot wrap
    function automatic logic addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        logic mis;
        logic low;
        logic high;
        mis  = (addr[1:0] != 2'b00);
        low  = (addr < base);
        high = ({1'b0, addr} >= ({1'b0, base} + span));
        return mis || low || high;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide RAM with byte-enabled synchronous write and async read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       idx,
    input  logic [LANES-1:0]    be,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [LANES-1:0] req_be,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_t state;
    state_t state_nxt;

    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_nxt;

    logic             lat_we;
    logic             lat_err;
    logic [AW-1:0]    lat_idx;
    logic [LANES-1:0] lat_be;
    logic [31:0]      lat_wdata;

    logic             req_err;
    logic [AW-1:0]    req_idx;
    logic             cur_we;
    logic             cur_err;
    logic [AW-1:0]    arr_idx;
    logic [31:0]      arr_rdata;
    logic             commit;
    logic             mem_we;
    logic             enter_resp;

    logic             valid_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    assign req_err = addr_err(req_addr, BASE_ADDR, SPAN);
    assign req_idx = req_addr[AW+1:2] - BASE_ADDR[AW+1:2];

    // In IDLE the request itself feeds the array so LATENCY=1 can respond
    assign cur_we  = (state == IDLE) ? req_we  : lat_we;
    assign cur_err = (state == IDLE) ? req_err : lat_err;
    assign arr_idx = (state == IDLE) ? req_idx : lat_idx;

    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = LAT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt <= LAT_W'(1)) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - LAT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
                commit    = lat_we && !lat_err;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign mem_we     = commit && !rest;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk) begin
        if (rest) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && req_valid) begin
            lat_we    <= req_we;
            lat_err   <= req_err;
            lat_idx   <= req_idx;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= enter_resp;
            rdata_q <= (enter_resp && !cur_we && !cur_err) ? arr_rdata : '0;
            err_q   <= enter_resp && cur_err;
        end
    end

    // A reset landing on the RESP cycle cancels the strobe as well
    assign resp_valid = valid_q && !rest;
    assign resp_rdata = rest ? '0 : rdata_q;
    assign resp_err   = err_q && !rest;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .idx  (arr_idx),
        .be   (lat_be),
        .wdata(lat_wdata),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a transaction-level model.
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        sw_valid [2];
    logic        sw_ready [2];
    logic        sw_rv    [2];
    logic [31:0] sw_rdata [2];
    logic        sw_err   [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_main (
        .clk(clk), .rest(rest), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_lat1 (
        .clk(clk), .rest(rest), .req_valid(sw_valid[0]), .req_ready(sw_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .resp_valid(sw_rv[0]),
        .resp_rdata(sw_rdata[0]), .resp_err(sw_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(15)) u_lat15 (
        .clk(clk), .rest(rest), .req_valid(sw_valid[1]), .req_ready(sw_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .resp_valid(sw_rv[1]),
        .resp_rdata(sw_rdata[1]), .resp_err(sw_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [DEPTH];
    bit          pend = 0;
    int          due = 0;
    int          free_at = 0;
    bit          p_we;
    bit          p_err;
    int          p_idx;
    logic [3:0]  p_be;
    logic [31:0] p_wdata;

    function automatic bit model_err(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la % 4 != 0) || (la < longint'(BASE)) ||
               (la >= longint'(BASE) + 4 * DEPTH);
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (rest) begin
            pend = 0;
            free_at = cyc + 1;
        end else begin
            if (pend && due == cyc) begin
                if (p_we && !p_err) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[b]) ref_mem[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
                end
                pend = 0;
            end
            if (req_valid && cyc >= free_at) begin
                pend    = 1;
                due     = cyc + LAT;
                free_at = cyc + LAT + 1;
                p_we    = req_we;
                p_err   = model_err(req_addr);
                p_idx   = int'((req_addr - BASE) >> 2) % DEPTH;
                p_be    = req_be;
                p_wdata = req_wdata;
            end
        end
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    int          npulse = 0;
    int          last_cyc = -1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        bit          ev;
        logic [31:0] ed;
        if (cyc >= 1) begin
            ev = pend && (due == cyc) && !rest;
            ed = (ev && !p_we && !p_err) ? ref_mem[p_idx] : 32'h0;
            chk("req_ready", 32'(req_ready), 32'(cyc >= free_at));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("resp_rdata", resp_rdata, ed);
            chk("resp_err", 32'(resp_err), 32'(ev && p_err));
        end
        if (resp_valid) begin
            npulse++;
            last_cyc   = cyc;
            last_rdata = resp_rdata;
            last_err   = resp_err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d, input int kill, output int acc);
        logic r;
        bit   ok;
        ok = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            r = req_ready;
            @(posedge clk);
            #1;
            if (r && !rest) ok = 1;
        end
        req_valid = 1'b0;
        acc = cyc - 1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no handshake expected one within 20 cycles");
        end
        if (kill > 0) begin
            repeat (kill - 1) begin @(posedge clk); #1; end
            rest = 1'b1;
            @(posedge clk);
            #1;
            rest = 1'b0;
        end
        repeat (LAT) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_addr();
        int s;
        s = $urandom_range(0, 9);
        if (s < 6) return 32'($urandom_range(0, 63)) << 2;
        if (s == 6) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        if (s == 7) return 32'h1000 + (32'($urandom_range(0, 1000)) << 2);
        if (s == 8) return 32'hFFC;
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    task automatic sweep(input int k, input int lat);
        logic r;
        int   nacc;
        int   nresp;
        int   acc_at [4];
        int   resp_at [4];
        nacc = 0;
        nresp = 0;
        rest = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rest = 1'b0;
        req_we   = 1'b0;
        req_addr = 32'h40;
        sw_valid[k] = 1'b1;
        for (int t = 0; t < 6 * (lat + 1) + 4; t++) begin
            @(negedge clk);
            r = sw_ready[k];
            if (sw_rv[k]) begin
                if (nresp < 4) resp_at[nresp] = cyc;
                nresp++;
                chk("sweep_rdata", sw_rdata[k], 32'h0);
                chk("sweep_err", 32'(sw_err[k]), 32'h0);
            end
            @(posedge clk);
            #1;
            if (r && sw_valid[k]) begin
                acc_at[nacc] = cyc - 1;
                nacc++;
                if (nacc == 4) sw_valid[k] = 1'b0;
            end
        end
        sw_valid[k] = 1'b0;
        chk("sweep_accepts", 32'(nacc), 32'd4);
        chk("sweep_pulses", 32'(nresp), 32'd4);
        if (nacc == 4 && nresp == 4) begin
            for (int i = 1; i < 4; i++)
                chk("sweep_spacing", 32'(acc_at[i] - acc_at[i-1]), 32'(lat + 1));
            for (int i = 0; i < 4; i++)
                chk("sweep_latency", 32'(resp_at[i] - acc_at[i]), 32'(lat));
        end
    endtask

    initial begin
        int acc;
        int p0;
        sw_valid[0] = 1'b0;
        sw_valid[1] = 1'b0;

        rest = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;
        rest = 1'b0;

        p0 = npulse;
        do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, acc);
        chk("st_pulse", 32'(npulse), 32'(p0 + 1));
        chk("st_latency", 32'(last_cyc - acc), 32'd2);
        chk("st_err", 32'(last_err), 32'd0);
        chk("st_rdata", last_rdata, 32'd0);
        do_req(1'b0, 32'h10, 4'h0, 32'h0, 0, acc);
        chk("ld_full", last_rdata, 32'hDEADBEEF);

        do_req(1'b1, 32'h10, 4'b0010, 32'h0000_5500, 0, acc);
        do_req(1'b0, 32'h10, 4'hF, 32'hFFFF_FFFF, 0, acc);
        chk("ld_partial", last_rdata, 32'hDEAD55EF);

        do_req(1'b0, 32'h13, 4'hF, 32'h0, 0, acc);
        chk("mis_err", 32'(last_err), 32'd1);
        chk("mis_rdata", last_rdata, 32'd0);

        do_req(1'b1, BASE + 32'(4 * DEPTH), 4'hF, 32'hFFFF_FFFF, 0, acc);
        chk("oor_err", 32'(last_err), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            do_req(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0, 0, acc);

        p0 = npulse;
        do_req(1'b1, 32'h20, 4'hF, 32'h1234_5678, 1, acc);
        chk("kill_no_pulse", 32'(npulse), 32'(p0));
        do_req(1'b0, 32'h20, 4'hF, 32'h0, 0, acc);
        chk("kill_ld", last_rdata, 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [31:0] a;
            int          kill;
            we   = 1'($urandom_range(0, 1));
            a    = rand_addr();
            kill = ($urandom_range(0, 19) == 0) ? $urandom_range(1, LAT) : 0;
            do_req(we, a, 4'($urandom()), $urandom(), kill, acc);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        sweep(0, 1);
        sweep(1, 15);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
